alu_mult_seq: RTL and testbench

//  Multi-cycle unsigned 16x16->16 multiply controller that time-shares the existing 16-bit ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mult_seq_if.sv | 28 ++
 rtl/alu_mult_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_mult_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the multiply sequencer and its parent.
//   OP_*      : 3-bit ALU operation selects (logic group has bit 2 set)
//   SH_SLL    : shift-left-logical sub-op; the ALU shift op is {1'b0, SH_*}
//   MULT_W    : operand/result width of the shared ALU
//   mult_state_t : multiply sequencer state encoding
package alu_pkg;

  localparam int MULT_W = 16;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  localparam logic [1:0] SH_SLL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADD   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } mult_state_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Request/response bundle of the multiply sequencer.
//   req_valid/req_ready : request handshake, accepted when both are high
//   mcand/mplier        : operands, sampled on accept
//   done                : one-cycle pulse, result/ofl valid
//   result/ofl          : low half of the product and overflow flag
// master = requester side, slave = the sequencer.
interface alu_mult_seq_if;
  import alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [MULT_W-1:0] mcand;
  logic [MULT_W-1:0] mplier;
  logic              done;
  logic [MULT_W-1:0] result;
  logic              ofl;

  modport master (
    output req_valid, mcand, mplier,
    input  req_ready, done, result, ofl
  );

  modport slave (
    input  req_valid, mcand, mplier,
    output req_ready, done, result, ofl
  );

endinterface

// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned 16x16->16 multiply controller that borrows the
// execute-stage ALU. Each iteration issues an ALU ADD (acc += bit ? mc : 0)
// followed by an ALU shift-left of the multiplicand; the multiplier is
// shifted right locally. The ALU itself lives in the parent, which muxes
// alu_* onto the ALU ports while req_ready is low.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req (slave modport)   : request handshake, operands, done/result/ofl
//   alu_a, alu_b, alu_op  : ALU operand/op drive (idle drive = ADD 0+0)
//   alu_cin/inva/invb/sign: tied low (plain unsigned add, ofl = carry-out)
//   alu_out, alu_ofl      : same-cycle ALU result and carry flag
//
// Build option: MULT_EARLY_TERM_EN skips ADD for zero multiplier bits and
// stops once the remaining multiplier is zero; without it every operation
// runs all 16 ADD/SHIFT pairs and done arrives in cycle 33 after accept.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mult_seq_if.slave    req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl
);

  mult_state_t      state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s;
  logic [WIDTH-1:0] mc_r, mc_nxt_s;
  logic [WIDTH-1:0] mp_r, mp_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ofl_r, ofl_nxt_s;
  logic             ready_r, done_r, ofl_out_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH-1:0] mp_shr_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             last_iter_s;
  logic             term_s;
  logic             shift_lost_s;

  assign mp_shr_s    = mp_r >> 1;
  assign cnt_inc_s   = cnt_r + CNT_W'(1);
  assign last_iter_s = (cnt_inc_s == CNT_W'(WIDTH));
  // A set bit shifted out of mc is lost product weight only if a later
  // multiplier bit would still have added it in.
  assign shift_lost_s = mc_r[WIDTH-1] & (|mp_shr_s);

`ifdef MULT_EARLY_TERM_EN
  assign term_s = last_iter_s | (mp_shr_s == '0);
`else
  assign term_s = last_iter_s;
`endif

  // Next-state, datapath update and ALU drive for the current state.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    mc_nxt_s    = mc_r;
    mp_nxt_s    = mp_r;
    cnt_nxt_s   = cnt_r;
    ofl_nxt_s   = ofl_r;
    alu_op      = OP_ADD;
    alu_a       = '0;
    alu_b       = '0;
    case (state_r)
      ST_IDLE: begin
        if (req.req_valid) begin
          mc_nxt_s  = req.mcand;
          mp_nxt_s  = req.mplier;
          acc_nxt_s = '0;
          cnt_nxt_s = '0;
          ofl_nxt_s = 1'b0;
`ifdef MULT_EARLY_TERM_EN
          if (req.mplier == '0) begin
            state_nxt_s = ST_DONE;
          end else if (req.mplier[0]) begin
            state_nxt_s = ST_ADD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
`else
          state_nxt_s = ST_ADD;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        alu_a       = acc_r;
        alu_b       = mp_r[0] ? mc_r : '0;
        acc_nxt_s   = alu_out;
        ofl_nxt_s   = ofl_r | alu_ofl;
        state_nxt_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_op    = {1'b0, SH_SLL};
        alu_a     = mc_r;
        alu_b     = WIDTH'(1);
        mc_nxt_s  = alu_out;
        mp_nxt_s  = mp_shr_s;
        cnt_nxt_s = cnt_inc_s;
        ofl_nxt_s = ofl_r | shift_lost_s;
        if (term_s) begin
          state_nxt_s = ST_DONE;
        end else begin
`ifdef MULT_EARLY_TERM_EN
          state_nxt_s = mp_shr_s[0] ? ST_ADD : ST_SHIFT;
`else
          state_nxt_s = ST_ADD;
`endif
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      acc_r   <= '0;
      mc_r    <= '0;
      mp_r    <= '0;
      cnt_r   <= '0;
      ofl_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      mc_r    <= mc_nxt_s;
      mp_r    <= mp_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ofl_r   <= ofl_nxt_s;
    end
  end

  // Registered handshake/result outputs. The result is captured on entry
  // to DONE so it is already valid in the cycle done is high; acc and the
  // sticky flag are final by then because DONE is only entered from
  // accept (mplier == 0) or after a SHIFT, neither of which changes acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      result_r  <= '0;
      ofl_out_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        result_r  <= acc_nxt_s;
        ofl_out_r <= ofl_nxt_s;
      end else begin
        result_r  <= result_r;
        ofl_out_r <= ofl_out_r;
      end
    end
  end

  assign req.req_ready = ready_r;
  assign req.done      = done_r;
  assign req.result    = result_r;
  assign req.ofl       = ofl_out_r;

  assign alu_cin  = 1'b0;
  assign alu_inva = 1'b0;
  assign alu_invb = 1'b0;
  assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_inva, alu_invb, alu_sign, alu_ofl;

  alu_mult_seq_if bus();

  alu_mult_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl)
  );

  always #5 clk = ~clk;

  // Parent-side ALU: unsigned add with carry-out, shift-left by alu_b[3:0].
  always_comb begin
    alu_out = 16'h0000;
    alu_ofl = 1'b0;
    case (alu_op)
      OP_ADD:           {alu_ofl, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      {1'b0, SH_SLL}:   alu_out = alu_a << alu_b[3:0];
      default:          alu_out = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] mp;
    logic [15:0] res;
    logic        ofl;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          acc_cyc = 0;
  int          last_done_cyc = 0;
  logic [63:0] op_bits = 64'd0;
  int          op_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Expected ALU op sequence (1=ADD, 0=SHIFT) and its length for a multiplier.
  function automatic void exp_ops(input logic [15:0] mp, output logic [63:0] bits, output int len);
    bits = 64'd0;
    len  = 0;
    for (int i = 0; i < 16; i++) begin
`ifdef MULT_EARLY_TERM_EN
      if ((mp >> i) != 16'h0000) begin
        if (mp[i]) begin
          bits = {bits[62:0], 1'b1};
          len++;
        end
        bits = {bits[62:0], 1'b0};
        len++;
      end
`else
      bits = {bits[61:0], 2'b10};
      len = len + 2;
`endif
    end
  endfunction

  // Monitor: scoreboard pops on done, ALU drive and accept tracking.
  initial begin
    exp_t        e;
    logic [63:0] eb;
    int          el;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        op_bits = 64'd0;
        op_len  = 0;
      end else begin
        if (bus.done) begin
          n_done++;
          last_done_cyc = cyc;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got=done with empty scoreboard want=no done");
          end else begin
            e = sb.pop_front();
            exp_ops(e.mp, eb, el);
            chk("result", 64'(bus.result), 64'(e.res));
            chk("ofl", 64'(bus.ofl), 64'(e.ofl));
            chk("latency", 64'(cyc - acc_cyc), 64'(el + 1));
            chk("op_seq", op_bits, eb);
            chk("op_count", 64'(op_len), 64'(el));
          end
          op_bits = 64'd0;
          op_len  = 0;
          chk("ready_in_done", 64'(bus.req_ready), 64'd0);
          chk("done_drive", {45'd0, alu_op, alu_a, alu_b}, {45'd0, OP_ADD, 32'd0});
        end else if (!bus.req_ready) begin
          if (alu_op == OP_ADD) begin
            op_bits = {op_bits[62:0], 1'b1};
            op_len++;
          end else if (alu_op == {1'b0, SH_SLL}) begin
            op_bits = {op_bits[62:0], 1'b0};
            op_len++;
            chk("shift_amount", 64'(alu_b), 64'd1);
          end else begin
            chk("busy_op", 64'(alu_op), 64'(OP_ADD));
          end
        end else begin
          chk("idle_drive", {45'd0, alu_op, alu_a, alu_b}, {45'd0, OP_ADD, 32'd0});
          if (bus.req_valid) begin
            n_acc++;
            acc_cyc = cyc;
          end
        end
        chk("alu_tied", {60'd0, alu_cin, alu_inva, alu_invb, alu_sign}, 64'd0);
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_timeout", 64'(n_done >= target), 64'd1);
  endtask

  // Present a request until accepted, then scramble the operand bus.
  task automatic issue(input logic [15:0] mc, input logic [15:0] mp);
    int n0 = n_acc;
    int k  = 0;
    @(posedge clk);
    #1;
    bus.mcand     = mc;
    bus.mplier    = mp;
    bus.req_valid = 1'b1;
    while (n_acc == n0 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("accept_timeout", 64'(n_acc > n0), 64'd1);
    bus.req_valid = 1'b0;
    bus.mcand     = 16'hDEAD;
    bus.mplier    = 16'hBEEF;
  endtask

  task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                        input logic [15:0] res, input logic ofl);
    int d0 = n_done;
    sb.push_back('{mp: mp, res: res, ofl: ofl});
    issue(mc, mp);
    wait_done(d0 + 1, 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=no finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, a0, d1;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.mcand     = 16'h0000;
    bus.mplier    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", {47'd0, bus.ofl, bus.result}, 64'd0);
    chk("rst_drive", {45'd0, alu_op, alu_a, alu_b}, {45'd0, OP_ADD, 32'd0});
    rst_n = 1'b1;

    run_op(16'h0003, 16'h0005, 16'h000F, 1'b0);
    run_op(16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    run_op(16'h0100, 16'h0100, 16'h0000, 1'b1);
    run_op(16'h00FF, 16'h0101, 16'hFFFF, 1'b0);
    run_op(16'h1234, 16'h0001, 16'h1234, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    run_op(16'h8000, 16'h0002, 16'h0000, 1'b1);
    run_op(16'h012C, 16'h00C8, 16'hEA60, 1'b0);
    run_op(16'h0001, 16'h8000, 16'h8000, 1'b0);
    run_op(16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    run_op(16'h00FF, 16'h0100, 16'hFF00, 1'b0);
    run_op(16'h7FFF, 16'h0003, 16'h7FFD, 1'b1);

    // req_valid held across two operations: one accept each, 1-cycle gap.
    a0 = n_acc;
    d0 = n_done;
    sb.push_back('{mp: 16'h0003, res: 16'h0033, ofl: 1'b0});
    sb.push_back('{mp: 16'h0003, res: 16'h0033, ofl: 1'b0});
    @(posedge clk);
    #1;
    bus.mcand     = 16'h0011;
    bus.mplier    = 16'h0003;
    bus.req_valid = 1'b1;
    wait_done(d0 + 1, 60);
    d1 = last_done_cyc;
    wait_done(d0 + 2, 60);
    bus.req_valid = 1'b0;
    chk("held_accepts", 64'(n_acc - a0), 64'd2);
    chk("held_gap", 64'(acc_cyc), 64'(d1 + 1));

    // Asynchronous reset in cycle 4 of 3*5 (previous result is non-zero).
    run_op(16'h7FFF, 16'h0003, 16'h7FFD, 1'b1);
    d0 = n_done;
    sb.push_back('{mp: 16'h0005, res: 16'h000F, ofl: 1'b0});
    issue(16'h0003, 16'h0005);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_result", {47'd0, bus.ofl, bus.result}, 64'd0);
    chk("abort_drive", {45'd0, alu_op, alu_a, alu_b}, {45'd0, OP_ADD, 32'd0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(n_done), 64'(d0));
    chk("abort_ready_after", 64'(bus.req_ready), 64'd1);

    run_op(16'h0003, 16'h0005, 16'h000F, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
